// File: rtl/ip_tx_pkg.sv
// rtl/ip_tx_pkg.sv - shared types and constants for the IPv4 transmit header path
//
// Contents:
//   state_t        FSM encoding for ip_tx_header
//   IP_HDR_LEN     IPv4 header length in bytes (no options)
//   IP_VER_IHL     version 4 / IHL 5 byte
//   IP_FLAGS_WORD  flags/fragment word with DF set
//   ETHERTYPE_IPV4 ethertype written when the Ethernet header is built locally
//   IP_PROTO_UDP   protocol number for UDP
//   ETH_HDR_BYTES  Ethernet header length in bytes
//   pick_byte()    selects byte n (MSB first) from a 160-bit header image
package ip_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC     = 3'd1,
    FOLD     = 3'd2,
    ETHHDR   = 3'd3,
    WRHDR    = 3'd4,
    SEND     = 3'd5,
    WAITDONE = 3'd6
  } state_t;

  localparam logic [15:0] IP_HDR_LEN     = 16'd20;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [15:0] IP_FLAGS_WORD  = 16'h4000;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [4:0]  ETH_HDR_BYTES  = 5'd14;

  // Byte 0 is the most significant byte of the image, so headers can be
  // written in network order by walking idx upward.
  function automatic logic [7:0] pick_byte(input logic [159:0] vec,
                                           input logic [4:0]   idx);
    logic [159:0] sh;
    sh = vec << {idx, 3'b000};
    return sh[159:152];
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// rtl/ip_csum_acc.sv - ones-complement checksum accumulator with clear/add/fold
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         zero the accumulator (wins over add)
//   add           accumulate word
//   word          16-bit word to accumulate
//   fold          register the folded, inverted checksum
//   csum          last folded checksum (ones complement of the folded sum)
//
// The 20-bit accumulator holds up to 16 full-scale words without overflow,
// which covers an IPv4 header and leaves headroom for other reuse.
module ip_csum_acc (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        add,
  input  logic [15:0] word,
  input  logic        fold,
  output logic [15:0] csum
);

  logic [19:0] acc;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // A second end-around carry is enough: when the first fold carries out,
  // its low 16 bits are small, so adding one more cannot carry again.
  assign fold1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
  assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= 20'h0;
      csum <= 16'h0;
    end else begin
      if (clear) begin
        acc <= 20'h0;
      end else if (add) begin
        acc <= acc + {4'h0, word};
      end
      if (fold) begin
        csum <= ~fold2;
      end
    end
  end

endmodule

// File: rtl/ip_tx_header.sv
// rtl/ip_tx_header.sv - builds the IPv4 header in the transmit DPRAM and requests MAC transmit
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   sendDatagram      one-cycle request from the UDP stage (ignored while busy)
//   sendDatagramSize  UDP length in bytes (header + payload)
//   destinationIP     destination IPv4 address
//   protocolIn        IP protocol field
//   tx_done_MAC       one-cycle pulse, MAC finished the frame
//   wrRAM/wrData/wrAddr  DPRAM write port (active only while writing headers)
//   sendFrame         one-cycle request to the MAC
//   frameSize         total Ethernet frame length, held until the next frame
//   busy              high from request accept until tx_done_MAC
//
// Build option: ETH_HDR_WRITE_EN - also writes the 14-byte Ethernet header
// at DPRAM 0x000..0x00D before the IP header (14 extra cycles of latency).
module ip_tx_header
  import ip_tx_pkg::*;
#(
  parameter logic [31:0] DEVICE_IP   = 32'h0a0105dd,
  parameter logic [7:0]  IP_TTL      = 8'h80,
  parameter logic [10:0] IP_HDR_BASE = 11'h00E,
  parameter logic [15:0] ETH_HDR_LEN = 16'd14,
  parameter logic [47:0] DEST_MAC    = 48'h00_00_00_00_00_00,
  parameter logic [47:0] DEVICE_MAC  = 48'h00_0A_35_00_00_01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sendDatagram,
  input  logic [15:0] sendDatagramSize,
  input  logic [31:0] destinationIP,
  input  logic [7:0]  protocolIn,
  input  logic        tx_done_MAC,
  output logic        wrRAM,
  output logic [7:0]  wrData,
  output logic [10:0] wrAddr,
  output logic        sendFrame,
  output logic [15:0] frameSize,
  output logic        busy
);

  localparam logic [4:0] CALC_LAST = 5'd8;
  localparam logic [4:0] ETH_LAST  = ETH_HDR_BYTES - 5'd1;
  localparam logic [4:0] HDR_LAST  = 5'(IP_HDR_LEN - 16'd1);

  state_t       state;
  state_t       state_nxt;
  logic [4:0]   cnt;
  logic [4:0]   cnt_nxt;

  logic [15:0]  tot_len;
  logic [31:0]  dst_ip;
  logic [7:0]   protocol;
  logic [15:0]  ident;

  logic         latch_req;
  logic         acc_clear;
  logic         acc_add;
  logic         acc_fold;
  logic         ident_inc;
  logic [15:0]  acc_word;
  logic [15:0]  csum;

  logic         wrRAM_d;
  logic [7:0]   wrData_d;
  logic [10:0]  wrAddr_d;
  logic         sendFrame_d;
  logic [15:0]  frameSize_d;
  logic         busy_d;

  logic [159:0] ip_hdr;
  logic [111:0] eth_hdr;

  // Header images in network order; byte 10/11 is the folded checksum.
  assign ip_hdr  = {IP_VER_IHL, 8'h00, tot_len, ident, IP_FLAGS_WORD,
                    IP_TTL, protocol, csum, DEVICE_IP, dst_ip};
  assign eth_hdr = {DEST_MAC, DEVICE_MAC, ETHERTYPE_IPV4};

  ip_csum_acc u_csum (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (acc_clear),
    .add     (acc_add),
    .word    (acc_word),
    .fold    (acc_fold),
    .csum    (csum)
  );

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (sendDatagram) state_nxt = CALC;
      CALC:     if (cnt == CALC_LAST) state_nxt = FOLD;
`ifdef ETH_HDR_WRITE_EN
      FOLD:     state_nxt = ETHHDR;
      ETHHDR:   if (cnt == ETH_LAST) state_nxt = WRHDR;
`else
      FOLD:     state_nxt = WRHDR;
`endif
      WRHDR:    if (cnt == HDR_LAST) state_nxt = SEND;
      SEND:     state_nxt = WAITDONE;
      // Completion wins; a request arriving in the same cycle is dropped
      // because it is only sampled in IDLE.
      WAITDONE: if (tx_done_MAC) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // The phase counter restarts on every state change, so each state sees
  // 0..N-1 without needing its own load logic.
  assign cnt_nxt = ((state_nxt != state) || (state == IDLE)) ? 5'd0 : cnt + 5'd1;

  // --------------------------------------------------------------- outputs
  always_comb begin
    latch_req   = 1'b0;
    acc_clear   = 1'b0;
    acc_add     = 1'b0;
    acc_fold    = 1'b0;
    ident_inc   = 1'b0;
    acc_word    = 16'h0000;
    wrRAM_d     = 1'b0;
    wrData_d    = 8'h00;
    wrAddr_d    = 11'h000;
    sendFrame_d = 1'b0;
    frameSize_d = frameSize;
    busy_d      = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (sendDatagram) begin
          latch_req = 1'b1;
          acc_clear = 1'b1;
        end
      end
      CALC: begin
        acc_add = 1'b1;
        // The checksum word itself is skipped (counts as zero).
        case (cnt)
          5'd0:    acc_word = {IP_VER_IHL, 8'h00};
          5'd1:    acc_word = tot_len;
          5'd2:    acc_word = ident;
          5'd3:    acc_word = IP_FLAGS_WORD;
          5'd4:    acc_word = {IP_TTL, protocol};
          5'd5:    acc_word = DEVICE_IP[31:16];
          5'd6:    acc_word = DEVICE_IP[15:0];
          5'd7:    acc_word = dst_ip[31:16];
          5'd8:    acc_word = dst_ip[15:0];
          default: acc_word = 16'h0000;
        endcase
      end
      FOLD: begin
        acc_fold = 1'b1;
      end
      ETHHDR: begin
        wrRAM_d  = 1'b1;
        wrAddr_d = {6'b0, cnt};
        wrData_d = pick_byte({eth_hdr, 48'h0}, cnt);
      end
      WRHDR: begin
        wrRAM_d  = 1'b1;
        wrAddr_d = IP_HDR_BASE + {6'b0, cnt};
        wrData_d = pick_byte(ip_hdr, cnt);
      end
      SEND: begin
        sendFrame_d = 1'b1;
        frameSize_d = ETH_HDR_LEN + tot_len;
      end
      WAITDONE: begin
        ident_inc = tx_done_MAC;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 5'd0;
      tot_len   <= 16'h0000;
      dst_ip    <= 32'h0;
      protocol  <= 8'h00;
      ident     <= 16'h0000;
      wrRAM     <= 1'b0;
      wrData    <= 8'h00;
      wrAddr    <= 11'h000;
      sendFrame <= 1'b0;
      frameSize <= 16'h0000;
      busy      <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (latch_req) begin
        // Total length wraps silently for oversize UDP lengths.
        tot_len  <= sendDatagramSize + IP_HDR_LEN;
        dst_ip   <= destinationIP;
        protocol <= protocolIn;
      end
      if (ident_inc) begin
        ident <= ident + 16'd1;
      end
      wrRAM     <= wrRAM_d;
      wrData    <= wrData_d;
      wrAddr    <= wrAddr_d;
      sendFrame <= sendFrame_d;
      frameSize <= frameSize_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_ip_tx_header.sv
// tb/tb_ip_tx_header.sv - directed self-checking bench for ip_tx_header
module tb_ip_tx_header;

`ifdef ETH_HDR_WRITE_EN
  localparam int FRAME_LAT = 45;
  localparam int HDR_FIRST = 25;
  localparam int WR_CNT    = 34;
`else
  localparam int FRAME_LAT = 31;
  localparam int HDR_FIRST = 11;
  localparam int WR_CNT    = 20;
`endif
  localparam int IP_BASE = 14;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sendDatagram = 1'b0;
  logic [15:0] sendDatagramSize = 16'h0;
  logic [31:0] destinationIP = 32'h0;
  logic [7:0]  protocolIn = 8'h0;
  logic        tx_done_MAC = 1'b0;
  logic        wrRAM;
  logic [7:0]  wrData;
  logic [10:0] wrAddr;
  logic        sendFrame;
  logic [15:0] frameSize;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_total = 0;
  int frame_total = 0;
  int frame_cyc = 0;
  logic [7:0] mem [0:2047];
  int         wr_cyc [0:2047];

  ip_tx_header dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .sendDatagram     (sendDatagram),
    .sendDatagramSize (sendDatagramSize),
    .destinationIP    (destinationIP),
    .protocolIn       (protocolIn),
    .tx_done_MAC      (tx_done_MAC),
    .wrRAM            (wrRAM),
    .wrData           (wrData),
    .wrAddr           (wrAddr),
    .sendFrame        (sendFrame),
    .frameSize        (frameSize),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // DPRAM model and event recorder, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (wrRAM === 1'b1) begin
      mem[wrAddr] = wrData;
      wr_cyc[wrAddr] = cyc;
      wr_total = wr_total + 1;
    end
    if (sendFrame === 1'b1) begin
      frame_total = frame_total + 1;
      frame_cyc = cyc;
    end
  end

  function automatic logic [159:0] exp_hdr(input logic [15:0] id, input logic [15:0] ck);
    return {16'h4500, 16'h0520, id, 16'h4000, 16'h8011, ck, 32'h0a0105dd, 32'h0a0105ce};
  endfunction

  task automatic send_req(input logic [15:0] sz, input logic [31:0] dst,
                          input logic [7:0] pr, output int t0);
    @(negedge clk);
    sendDatagramSize = sz;
    destinationIP = dst;
    protocolIn = pr;
    sendDatagram = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    sendDatagram = 1'b0;
  endtask

  task automatic wait_frame(input int f0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (frame_total != f0) ok = 1'b1;
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    tx_done_MAC = 1'b1;
    @(negedge clk);
    tx_done_MAC = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({wrRAM, wrData, wrAddr, sendFrame, frameSize, busy} !== 38'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {wrRAM, wrData, wrAddr, sendFrame, frameSize, busy});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({wrRAM, sendFrame, busy, frameSize} !== 19'h0) begin
      errors++;
      $display("FAIL idle_after_reset got %h want 0", {wrRAM, sendFrame, busy, frameSize});
    end
  endtask

  task automatic test_basic();
    int t0;
    int w0;
    int f0;
    bit ok;
    logic [159:0] exp;
    logic [7:0] want;
    w0 = wr_total;
    f0 = frame_total;
    exp = exp_hdr(16'h0000, 16'hD620);
    send_req(16'd1292, 32'h0a0105ce, 8'h11, t0);
    wait_frame(f0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout sendFrame not seen"); end
    checks++;
    if (frame_cyc !== t0 + FRAME_LAT) begin
      errors++; $display("FAIL basic_frame_lat got %0d want %0d", frame_cyc - t0, FRAME_LAT);
    end
    checks++;
    if (wr_cyc[IP_BASE] !== t0 + HDR_FIRST) begin
      errors++; $display("FAIL basic_first_wr got %0d want %0d", wr_cyc[IP_BASE] - t0, HDR_FIRST);
    end
    checks++;
    if (wr_cyc[IP_BASE + 19] !== t0 + FRAME_LAT - 1) begin
      errors++; $display("FAIL basic_last_wr got %0d want %0d", wr_cyc[IP_BASE + 19] - t0, FRAME_LAT - 1);
    end
    checks++;
    if (wr_total - w0 !== WR_CNT) begin
      errors++; $display("FAIL basic_wr_count got %0d want %0d", wr_total - w0, WR_CNT);
    end
    checks++;
    if (frameSize !== 16'd1326) begin
      errors++; $display("FAIL basic_frame_size got %0d want 1326", frameSize);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_wait got %b want 1", busy); end
    for (int n = 0; n < 20; n++) begin
      want = 8'(exp >> (8 * (19 - n)));
      checks++;
      if (mem[IP_BASE + n] !== want) begin
        errors++; $display("FAIL basic_hdr byte %0d got %h want %h", n, mem[IP_BASE + n], want);
      end
    end
    pulse_done();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b want 0", busy); end
  endtask

  task automatic test_ident_inc();
    int t0;
    bit ok;
    logic [159:0] exp;
    logic [7:0] want;
    exp = exp_hdr(16'h0001, 16'hD61F);
    send_req(16'd1292, 32'h0a0105ce, 8'h11, t0);
    wait_frame(frame_total, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL inc_timeout sendFrame not seen"); end
    for (int n = 0; n < 20; n++) begin
      want = 8'(exp >> (8 * (19 - n)));
      checks++;
      if (mem[IP_BASE + n] !== want) begin
        errors++; $display("FAIL inc_hdr byte %0d got %h want %h", n, mem[IP_BASE + n], want);
      end
    end
    pulse_done();
  endtask

  task automatic test_ident_wrap();
    int t0;
    bit ok;
    logic [159:0] exp;
    logic [7:0] want;
    @(negedge clk);
    force dut.ident = 16'hFFFF;
    exp = exp_hdr(16'hFFFF, 16'hD620);
    send_req(16'd1292, 32'h0a0105ce, 8'h11, t0);
    wait_frame(frame_total, ok);
    release dut.ident;
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout sendFrame not seen"); end
    for (int n = 0; n < 20; n++) begin
      want = 8'(exp >> (8 * (19 - n)));
      checks++;
      if (mem[IP_BASE + n] !== want) begin
        errors++; $display("FAIL wrap_ffff_hdr byte %0d got %h want %h", n, mem[IP_BASE + n], want);
      end
    end
    pulse_done();
    exp = exp_hdr(16'h0000, 16'hD620);
    send_req(16'd1292, 32'h0a0105ce, 8'h11, t0);
    wait_frame(frame_total, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap2_timeout sendFrame not seen"); end
    for (int n = 0; n < 20; n++) begin
      want = 8'(exp >> (8 * (19 - n)));
      checks++;
      if (mem[IP_BASE + n] !== want) begin
        errors++; $display("FAIL wrap_zero_hdr byte %0d got %h want %h", n, mem[IP_BASE + n], want);
      end
    end
    pulse_done();
  endtask

  task automatic test_busy_ignore();
    int t0;
    int w0;
    int f0;
    bit ok;
    logic [159:0] exp;
    logic [7:0] want;
    w0 = wr_total;
    f0 = frame_total;
    exp = exp_hdr(16'h0001, 16'hD61F);
    send_req(16'd1292, 32'h0a0105ce, 8'h11, t0);
    while (cyc < t0 + HDR_FIRST + 9) @(negedge clk);
    send_req(16'h0100, 32'hdeadbeef, 8'h06, f0);
    f0 = frame_total;
    wait_frame(f0 - (f0 - frame_total), ok);
    if (frame_total == f0) wait_frame(f0, ok);
    else ok = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_timeout sendFrame not seen"); end
    send_req(16'h0200, 32'hcafef00d, 8'h06, t0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_waitdone got %b want 1", busy); end
    @(negedge clk);
    sendDatagram = 1'b1;
    tx_done_MAC = 1'b1;
    @(negedge clk);
    sendDatagram = 1'b0;
    tx_done_MAC = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_same_cycle got %b want 0", busy); end
    repeat (60) @(negedge clk);
    checks++;
    if (frame_total - f0 !== 1) begin
      errors++; $display("FAIL busy_frame_count got %0d want 1", frame_total - f0);
    end
    checks++;
    if (wr_total - w0 !== WR_CNT) begin
      errors++; $display("FAIL busy_wr_count got %0d want %0d", wr_total - w0, WR_CNT);
    end
    checks++;
    if (frameSize !== 16'd1326) begin
      errors++; $display("FAIL busy_frame_size got %0d want 1326", frameSize);
    end
    for (int n = 0; n < 20; n++) begin
      want = 8'(exp >> (8 * (19 - n)));
      checks++;
      if (mem[IP_BASE + n] !== want) begin
        errors++; $display("FAIL busy_hdr byte %0d got %h want %h", n, mem[IP_BASE + n], want);
      end
    end
  endtask

  task automatic test_totlen_wrap();
    int t0;
    bit ok;
    send_req(16'hFFF0, 32'h0a0105ce, 8'h11, t0);
    wait_frame(frame_total, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL totlen_timeout sendFrame not seen"); end
    checks++;
    if ({mem[IP_BASE + 2], mem[IP_BASE + 3]} !== 16'h0004) begin
      errors++; $display("FAIL totlen_wrap got %h want 0004", {mem[IP_BASE + 2], mem[IP_BASE + 3]});
    end
    checks++;
    if (frameSize !== 16'h0012) begin
      errors++; $display("FAIL totlen_frame_size got %h want 0012", frameSize);
    end
    pulse_done();
  endtask

  task automatic test_reset_mid();
    int t0;
    int f0;
    bit ok;
    logic [159:0] exp;
    logic [7:0] want;
    f0 = frame_total;
    send_req(16'd1292, 32'h0a0105ce, 8'h11, t0);
    while (cyc < t0 + 15) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({wrRAM, sendFrame, busy} !== 3'b000) begin
      errors++; $display("FAIL midreset_outputs got %b want 000", {wrRAM, sendFrame, busy});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (frame_total !== f0) begin
      errors++; $display("FAIL midreset_no_frame got %0d want 0", frame_total - f0);
    end
    exp = exp_hdr(16'h0000, 16'hD620);
    send_req(16'd1292, 32'h0a0105ce, 8'h11, t0);
    wait_frame(frame_total, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_timeout sendFrame not seen"); end
    checks++;
    if (frame_cyc !== t0 + FRAME_LAT) begin
      errors++; $display("FAIL midreset_frame_lat got %0d want %0d", frame_cyc - t0, FRAME_LAT);
    end
    for (int n = 0; n < 20; n++) begin
      want = 8'(exp >> (8 * (19 - n)));
      checks++;
      if (mem[IP_BASE + n] !== want) begin
        errors++; $display("FAIL midreset_hdr byte %0d got %h want %h", n, mem[IP_BASE + n], want);
      end
    end
    pulse_done();
  endtask

`ifdef ETH_HDR_WRITE_EN
  task automatic test_eth_hdr();
    int t0;
    bit ok;
    logic [111:0] exp;
    logic [7:0] want;
    exp = {48'h00_00_00_00_00_00, 48'h00_0A_35_00_00_01, 16'h0800};
    send_req(16'd1292, 32'h0a0105ce, 8'h11, t0);
    wait_frame(frame_total, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL eth_timeout sendFrame not seen"); end
    checks++;
    if (wr_cyc[0] !== t0 + 11) begin
      errors++; $display("FAIL eth_first_wr got %0d want 11", wr_cyc[0] - t0);
    end
    for (int n = 0; n < 14; n++) begin
      want = 8'(exp >> (8 * (13 - n)));
      checks++;
      if (mem[n] !== want) begin
        errors++; $display("FAIL eth_hdr byte %0d got %h want %h", n, mem[n], want);
      end
    end
    pulse_done();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ident_inc();
    test_ident_wrap();
    test_busy_ignore();
    test_totlen_wrap();
    test_reset_mid();
`ifdef ETH_HDR_WRITE_EN
    test_eth_hdr();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
